alu_cmd_sequencer: RTL and testbench

- Command front-end that sits directly upstream of the 16-bit ALU breadboard.
- Buffers (opcode, A, B) commands in a small FIFO and drives the ALU's a_in/b_in/opcode inputs one command at a time.
- Captures the ALU's final_output/error at the correct cycle and presents each result through a valid/ready response port.
- Lets upstream logic stream operations without tracking the ALU's register timing.

---
 rtl/alu_cmd_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
// Command front-end for the 16-bit ALU breadboard. Buffers (opcode, A, B)
// commands in a small FIFO, issues them to the ALU one at a time, and captures
// each ALU result two cycles after issue into a valid/ready response register.
// Issue sequence per command: IDLE -> ISSUE (drive ALU inputs) -> WAIT (ALU
// registers hold the command) -> IDLE (capture final_output/error).

module alu_cmd_sequencer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  // command port
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [3:0]                   cmd_opcode,
  input  logic [DATA_W-1:0]            cmd_a,
  input  logic [DATA_W-1:0]            cmd_b,
  // ALU drive / return
  output logic [DATA_W-1:0]            alu_a_in,
  output logic [DATA_W-1:0]            alu_b_in,
  output logic [3:0]                   alu_opcode,
  input  logic [DATA_W-1:0]            alu_result,
  input  logic                         alu_error,
  // response port
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [DATA_W-1:0]            rsp_result,
  output logic                         rsp_error,
  output logic [3:0]                   rsp_opcode,
  // status
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  // FIFO storage (datapath only, no reset needed: never read while empty)
  logic [3:0]        fifo_op_q [DEPTH];
  logic [DATA_W-1:0] fifo_a_q  [DEPTH];
  logic [DATA_W-1:0] fifo_b_q  [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              cmd_ready_q;
  logic              busy_q;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] alu_a_q, alu_b_q;
  logic [3:0]        alu_op_q;
  logic [3:0]        issued_op_q;

  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_result_q;
  logic              rsp_error_q;
  logic [3:0]        rsp_op_q;

  logic              push_s;
  logic              issue_s;
  logic              capture_s;
  logic [3:0]        head_op_s;
  logic [DATA_W-1:0] head_a_s;
  logic [DATA_W-1:0] head_b_s;

  // Handshake and issue decisions. cmd_ready is the registered !full flag, so a
  // full FIFO never accepts a push even when a pop happens on the same edge.
  always_comb begin
    push_s    = cmd_valid && cmd_ready_q;
    issue_s   = (state_q == ST_IDLE) && (count_q != {CNT_W{1'b0}}) &&
                (!rsp_valid_q || rsp_ready);
    capture_s = (state_q == ST_WAIT);
    head_op_s = fifo_op_q[rd_ptr_q];
    head_a_s  = fifo_a_q[rd_ptr_q];
    head_b_s  = fifo_b_q[rd_ptr_q];
  end

  // Next-state for the FIFO pointers and occupancy; pointers wrap modulo DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (issue_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, issue_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Next FSM state: IDLE waits for a command and a free response slot, ISSUE
  // and WAIT each last exactly one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (issue_s) begin
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Write an accepted command into the FIFO slot at the write pointer.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_op_q[wr_ptr_q] <= cmd_opcode;
      fifo_a_q[wr_ptr_q]  <= cmd_a;
      fifo_b_q[wr_ptr_q]  <= cmd_b;
    end
  end

  // FIFO bookkeeping plus registered cmd_ready / busy status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= {PTR_W{1'b0}};
      rd_ptr_q    <= {PTR_W{1'b0}};
      count_q     <= {CNT_W{1'b0}};
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      cmd_ready_q <= (count_d != FULL_CNT);
      busy_q      <= (state_d != ST_IDLE) || (count_d != {CNT_W{1'b0}});
    end
  end

  // Sequencer FSM with registered ALU drive and response capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      alu_a_q      <= {DATA_W{1'b0}};
      alu_b_q      <= {DATA_W{1'b0}};
      alu_op_q     <= 4'd0;
      issued_op_q  <= 4'd0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= {DATA_W{1'b0}};
      rsp_error_q  <= 1'b0;
      rsp_op_q     <= 4'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (issue_s) begin
            alu_a_q     <= head_a_s;
            alu_b_q     <= head_b_s;
            alu_op_q    <= head_op_s;
            issued_op_q <= head_op_s;
          end else begin
            alu_a_q  <= {DATA_W{1'b0}};
            alu_b_q  <= {DATA_W{1'b0}};
            alu_op_q <= 4'd0;
          end
        end
        ST_ISSUE: begin
          // ALU samples the command on this edge; fall back to NOP drive.
          alu_a_q  <= {DATA_W{1'b0}};
          alu_b_q  <= {DATA_W{1'b0}};
          alu_op_q <= 4'd0;
        end
        ST_WAIT: begin
          alu_a_q      <= {DATA_W{1'b0}};
          alu_b_q      <= {DATA_W{1'b0}};
          alu_op_q     <= 4'd0;
          rsp_result_q <= alu_result;
          rsp_error_q  <= alu_error;
          rsp_op_q     <= issued_op_q;
        end
        default: begin
          alu_a_q  <= {DATA_W{1'b0}};
          alu_b_q  <= {DATA_W{1'b0}};
          alu_op_q <= 4'd0;
        end
      endcase
      // A capture wins over a same-edge collection of the previous result.
      if (capture_s) begin
        rsp_valid_q <= 1'b1;
      end else if (rsp_valid_q && rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end else begin
        rsp_valid_q <= rsp_valid_q;
      end
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign count      = count_q;
  assign busy       = busy_q;
  assign alu_a_in   = alu_a_q;
  assign alu_b_in   = alu_b_q;
  assign alu_opcode = alu_op_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_error  = rsp_error_q;
  assign rsp_opcode = rsp_op_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Testbench for alu_cmd_sequencer: a simple registered ALU stand-in, a
// queue-based reference model checked every cycle, and literal expectations.

module tb_alu_cmd_sequencer;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 16;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_MUL = 4'h5;
  localparam logic [3:0] OP_DIV = 4'h6;
  localparam logic [3:0] OP_AND = 4'h8;
  localparam logic [3:0] OP_SUB = 4'hC;
  localparam logic [3:0] OP_RST = 4'hF;

  typedef struct packed {
    logic [3:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } cmd_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_opcode;
  logic [DATA_W-1:0] cmd_a, cmd_b;
  logic [DATA_W-1:0] alu_a_in, alu_b_in;
  logic [3:0]        alu_opcode;
  logic [DATA_W-1:0] alu_result = '0;
  logic              alu_error = 1'b0;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_error;
  logic [3:0]        rsp_opcode;
  logic [CNT_W-1:0]  count;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // model state
  cmd_t              m_q[$];
  int                m_age;     // cycles since issue, 0 = nothing in flight
  cmd_t              m_fly;
  cmd_t              m_drv;
  bit                m_rv;
  logic [DATA_W-1:0] m_res;
  logic              m_err;
  logic [3:0]        m_op;
  logic [DATA_W-1:0] m_prev = '0;   // ALU's current output as the model sees it
  logic              m_prev_err = 1'b0;

  // collected responses
  logic [DATA_W-1:0] got_q[$];
  int                got_cyc[$];

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_a_in(alu_a_in), .alu_b_in(alu_b_in), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_error(alu_error),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_error(rsp_error), .rsp_opcode(rsp_opcode),
    .count(count), .busy(busy)
  );

  // ALU behaviour: {error, result} for an opcode given its previous output
  function automatic logic [DATA_W:0] alu_fn(input logic [3:0] op,
      input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
      input logic [DATA_W-1:0] prev, input logic prev_err);
    case (op)
      OP_NOP:  return {prev_err, prev};
      OP_RST:  return '0;
      OP_ADD:  return {1'b0, a + b};
      OP_SUB:  return {1'b0, a - b};
      OP_MUL:  return {1'b0, a * b};
      OP_DIV:  return (b == '0) ? {1'b1, {DATA_W{1'b0}}} : {1'b0, a / b};
      OP_AND:  return {1'b0, a & b};
      default: return {1'b0, a ^ b};
    endcase
  endfunction

  // ALU stand-in: registers its inputs every edge; not reset by the sequencer
  always @(posedge clk) begin
    {alu_error, alu_result} <= alu_fn(alu_opcode, alu_a_in, alu_b_in, alu_result, alu_error);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("cmd_ready",  32'(cmd_ready),  32'(m_q.size() < DEPTH));
    chk("count",      32'(count),      32'(m_q.size()));
    chk("busy",       32'(busy),       32'((m_age != 0) || (m_q.size() != 0)));
    chk("alu_opcode", 32'(alu_opcode), 32'(m_drv.op));
    chk("alu_a_in",   32'(alu_a_in),   32'(m_drv.a));
    chk("alu_b_in",   32'(alu_b_in),   32'(m_drv.b));
    chk("rsp_valid",  32'(rsp_valid),  32'(m_rv));
    chk("rsp_result", 32'(rsp_result), 32'(m_res));
    chk("rsp_error",  32'(rsp_error),  32'(m_err));
    chk("rsp_opcode", 32'(rsp_opcode), 32'(m_op));
  endtask

  task automatic model_reset();
    m_q.delete();
    m_age = 0;
    m_fly = '0;
    m_drv = '0;
    m_rv  = 1'b0;
    m_res = '0;
    m_err = 1'b0;
    m_op  = 4'd0;
  endtask

  // advance one clock: predict from current inputs, then compare after the edge
  task automatic step();
    bit acc;
    bit iss;
    acc = cmd_valid && (m_q.size() < DEPTH);
    iss = (m_age == 0) && (m_q.size() != 0) && (!m_rv || rsp_ready);
    if (m_age == 2) begin
      m_rv  = 1'b1;
      m_res = m_prev;
      m_err = m_prev_err;
      m_op  = m_fly.op;
    end else if (m_rv && rsp_ready) begin
      m_rv = 1'b0;
    end
    if (m_age == 1) {m_prev_err, m_prev} = alu_fn(m_fly.op, m_fly.a, m_fly.b, m_prev, m_prev_err);
    if (iss) begin
      m_fly = m_q.pop_front();
      m_drv = m_fly;
      m_age = 1;
    end else begin
      m_drv = '0;
      m_age = (m_age == 1) ? 2 : 0;
    end
    if (acc) m_q.push_back({cmd_opcode, cmd_a, cmd_b});
    @(posedge clk);
    #1;
    cyc++;
    compare_all();
    if (rsp_valid && rsp_ready) begin
      got_q.push_back(rsp_result);
      got_cyc.push_back(cyc);
    end
  endtask

  task automatic set_cmd(input logic [3:0] op, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    cmd_valid  = 1'b1;
    cmd_opcode = op;
    cmd_a      = a;
    cmd_b      = b;
  endtask

  task automatic no_cmd();
    cmd_valid  = 1'b0;
    cmd_opcode = 4'd0;
    cmd_a      = '0;
    cmd_b      = '0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // assert reset between edges, check outputs at once, release after an edge
  task automatic do_reset(input string tag);
    no_cmd();
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_count"},     32'(count),     32'd0);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_alu_op"},    32'(alu_opcode), 32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    rsp_ready = 1'b1;
    no_cmd();
    model_reset();
    @(posedge clk);
    #1;
    compare_all();
    chk("por_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("por_count",     32'(count),     32'd0);
    reset = 1'b0;

    // mid-cycle reset while a command sits in flight
    set_cmd(OP_ADD, 16'd1, 16'd2);
    step();
    no_cmd();
    step();
    do_reset("rst_mid");

    // ADD 3+4: issue after E1, NOP drive after E2, response after E3
    set_cmd(OP_ADD, 16'd3, 16'd4);
    step();
    no_cmd();
    step();
    chk("add_issue_op", 32'(alu_opcode), 32'd4);
    chk("add_issue_a",  32'(alu_a_in),   32'd3);
    step();
    chk("add_wait_op",  32'(alu_opcode), 32'd0);
    step();
    chk("add_rsp_valid", 32'(rsp_valid),  32'd1);
    chk("add_rsp_res",   32'(rsp_result), 32'd7);
    chk("add_rsp_err",   32'(rsp_error),  32'd0);
    chk("add_rsp_op",    32'(rsp_opcode), 32'd4);
    steps(2);

    // back-to-back stream with rsp_ready held high
    got_q.delete();
    got_cyc.delete();
    set_cmd(OP_DIV, 16'd40000, 16'd5);
    step();
    set_cmd(OP_SUB, 16'd10, 16'd3);
    step();
    set_cmd(OP_AND, 16'h00FF, 16'h0F0F);
    step();
    no_cmd();
    steps(10);
    chk("stream_n", 32'(got_q.size()), 32'd3);
    if (got_q.size() == 3) begin
      chk("stream_r0", 32'(got_q[0]), 32'd8000);
      chk("stream_r1", 32'(got_q[1]), 32'd7);
      chk("stream_r2", 32'(got_q[2]), 32'h000F);
      chk("stream_gap0", 32'(got_cyc[1] - got_cyc[0]), 32'd3);
      chk("stream_gap1", 32'(got_cyc[2] - got_cyc[1]), 32'd3);
    end

    // backpressure and full FIFO
    rsp_ready = 1'b0;
    set_cmd(OP_ADD, 16'd100, 16'd23);
    step();
    no_cmd();
    steps(3);
    chk("bp_rsp_valid", 32'(rsp_valid),  32'd1);
    chk("bp_rsp_res",   32'(rsp_result), 32'd123);
    set_cmd(OP_SUB, 16'd9, 16'd2);
    step();
    set_cmd(OP_AND, 16'h1234, 16'h00F0);
    step();
    set_cmd(OP_ADD, 16'd1, 16'd1);
    step();
    set_cmd(OP_MUL, 16'd2, 16'd3);
    step();
    chk("full_count", 32'(count),     32'd4);
    chk("full_ready", 32'(cmd_ready), 32'd0);
    set_cmd(OP_ADD, 16'd50, 16'd50);
    step();
    no_cmd();
    step();
    chk("full_count_hold", 32'(count),      32'd4);
    chk("full_no_issue",   32'(alu_opcode), 32'd0);
    chk("full_res_held",   32'(rsp_result), 32'd123);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("bp_release_count", 32'(count),      32'd3);
    chk("bp_release_issue", 32'(alu_opcode), 32'(OP_SUB));
    steps(4);
    rsp_ready = 1'b1;
    steps(12);

    // reset during WAIT of MULTIPLY 6*7 with a second command queued
    set_cmd(OP_MUL, 16'd6, 16'd7);
    step();
    set_cmd(OP_ADD, 16'd8, 16'd8);
    step();
    no_cmd();
    step();
    do_reset("rst_wait");
    steps(4);
    chk("rst_wait_no_rsp", 32'(rsp_valid), 32'd0);
    got_q.delete();
    got_cyc.delete();
    set_cmd(OP_NOP, 16'd0, 16'd0);
    step();
    no_cmd();
    steps(4);
    chk("nop_n",   32'(got_q.size()), 32'd1);
    chk("nop_res", 32'(rsp_result),   32'd42);

    // RESET opcode clears the ALU output; a following NOP sees 0
    got_q.delete();
    got_cyc.delete();
    set_cmd(OP_ADD, 16'd3, 16'd4);
    step();
    set_cmd(OP_RST, 16'd0, 16'd0);
    step();
    set_cmd(OP_NOP, 16'd0, 16'd0);
    step();
    no_cmd();
    steps(10);
    chk("rstop_n", 32'(got_q.size()), 32'd3);
    if (got_q.size() == 3) begin
      chk("rstop_r0", 32'(got_q[0]), 32'd7);
      chk("rstop_r1", 32'(got_q[1]), 32'd0);
      chk("rstop_r2", 32'(got_q[2]), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
